// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk to a pixel tick, walks the H x V raster,
// issues pixel requests FETCH_LAT ticks early and emits aligned sync/DE/RGB.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int FETCH_LAT = 2,
    parameter int CW        = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic [9:0]      req_row,
    output logic [9:0]      req_col,
    output logic            req_valid,
    output logic            req_tick,
    input  logic [3*CW-1:0] pix_rgb,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [CW-1:0]   red,
    output logic [CW-1:0]   green,
    output logic [CW-1:0]   blue,
    output logic            frame_start,
    output logic [15:0]     frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // At least one pipeline slot exists so the array is legal; it is bypassed when FETCH_LAT is 0.
    localparam int PL      = (FETCH_LAT > 0) ? FETCH_LAT : 1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic sof;
    } attr_t;

    logic [DW-1:0]   div_q, div_d;
    logic [9:0]      col_q, col_d;
    logic [9:0]      row_q, row_d;
    attr_t           pipe_q [PL];
    attr_t           pipe_d [PL];
    attr_t           cur, tail;
    logic            tick;
    logic            req_tick_q, req_tick_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [3*CW-1:0] rgb_q, rgb_d;
    logic            frame_start_q, frame_start_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            started_q, started_d;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        cur.hs  = (col_q >= 10'(H_ACTIVE + H_FP)) && (col_q < 10'(H_ACTIVE + H_FP + H_SYNC));
        cur.vs  = (row_q >= 10'(V_ACTIVE + V_FP)) && (row_q < 10'(V_ACTIVE + V_FP + V_SYNC));
        cur.act = (row_q < 10'(V_ACTIVE)) && (col_q < 10'(H_ACTIVE));
        cur.sof = (row_q == 10'd0) && (col_q == 10'd0);
        tail    = (FETCH_LAT == 0) ? cur : pipe_q[PL-1];

        div_d         = div_q;
        col_d         = col_q;
        row_d         = row_q;
        pipe_d        = pipe_q;
        req_tick_d    = tick;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        started_d     = started_q;

        if (tick) begin
            div_d = '0;
            if (col_q == 10'(H_TOTAL - 1)) begin
                col_d = 10'd0;
                row_d = (row_q == 10'(V_TOTAL - 1)) ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end

            pipe_d[0] = cur;
            for (int i = 1; i < PL; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end

            hsync_d = tail.hs ? HS_POL : ~HS_POL;
            vsync_d = tail.vs ? VS_POL : ~VS_POL;
            de_d    = tail.act;
            rgb_d   = tail.act ? pix_rgb : '0;
            // The first start-of-frame after reset opens a frame rather than completing one.
            if (tail.sof) begin
                frame_start_d = 1'b1;
                started_d     = 1'b1;
                if (started_q) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            for (int i = 0; i < PL; i++) begin
                pipe_q[i] <= '0;
            end
            req_tick_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            started_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pipe_q        <= pipe_d;
            req_tick_q    <= req_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            started_q     <= started_d;
        end
    end

    assign req_row     = row_q;
    assign req_col     = col_q;
    assign req_valid   = cur.act;
    assign req_tick    = req_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign red         = rgb_q[3*CW-1 -: CW];
    assign green       = rgb_q[2*CW-1 -: CW];
    assign blue        = rgb_q[CW-1:0];
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (defaults, fast/active-high, small raster,
// one-pixel raster) checked against an arithmetic raster model indexed by clocks since reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic rst_a, rst_b, rst_d, rst_w;
    logic [8:0] pix_a, pix_b, pix_d;
    logic [2:0] pix_w;

    logic [9:0]  a_row, a_col, b_row, b_col, d_row, d_col, w_row, w_col;
    logic        a_valid, a_tick, a_hs, a_vs, a_de, a_fs;
    logic        b_valid, b_tick, b_hs, b_vs, b_de, b_fs;
    logic        d_valid, d_tick, d_hs, d_vs, d_de, d_fs;
    logic        w_valid, w_tick, w_hs, w_vs, w_de, w_fs;
    logic [2:0]  a_r, a_g, a_b, b_r, b_g, b_b, d_r, d_g, d_b;
    logic [0:0]  w_r, w_g, w_b;
    logic [15:0] a_fc, b_fc, d_fc, w_fc;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .req_row(a_row), .req_col(a_col), .req_valid(a_valid),
        .req_tick(a_tick), .pix_rgb(pix_a), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .red(a_r), .green(a_g), .blue(a_b), .frame_start(a_fs), .frame_count(a_fc));

    vga_timing_gen #(.CLK_DIV(1), .HS_POL(1'b1), .FETCH_LAT(0)) u_b (
        .clk(clk), .rst(rst_b), .req_row(b_row), .req_col(b_col), .req_valid(b_valid),
        .req_tick(b_tick), .pix_rgb(pix_b), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .red(b_r), .green(b_g), .blue(b_b), .frame_start(b_fs), .frame_count(b_fc));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(2), .V_BP(1), .CLK_DIV(3), .FETCH_LAT(3)) u_d (
        .clk(clk), .rst(rst_d), .req_row(d_row), .req_col(d_col), .req_valid(d_valid),
        .req_tick(d_tick), .pix_rgb(pix_d), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .red(d_r), .green(d_g), .blue(d_b), .frame_start(d_fs), .frame_count(d_fc));

    vga_timing_gen #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0), .V_ACTIVE(1), .V_FP(0),
                     .V_SYNC(0), .V_BP(0), .CLK_DIV(1), .FETCH_LAT(1), .CW(1)) u_w (
        .clk(clk), .rst(rst_w), .req_row(w_row), .req_col(w_col), .req_valid(w_valid),
        .req_tick(w_tick), .pix_rgb(pix_w), .hsync(w_hs), .vsync(w_vs), .de(w_de),
        .red(w_r), .green(w_g), .blue(w_b), .frame_start(w_fs), .frame_count(w_fc));

    // Clock edges since each instance last sampled reset high.
    int e_a = 0, e_b = 0, e_d = 0, e_w = 0;
    always @(posedge clk) begin
        e_a <= rst_a ? 0 : e_a + 1;
        e_b <= rst_b ? 0 : e_b + 1;
        e_d <= rst_d ? 0 : e_d + 1;
        e_w <= rst_w ? 0 : e_w + 1;
    end

    typedef struct packed {
        int          p;
        int          pc;
        logic [9:0]  row;
        logic [9:0]  col;
        logic        rv;
        logic        tick;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    // Tick n = e/div; requests show pixel index n, outputs show pixel index n-1-lat.
    function automatic exp_t model(input int ha, hf, hw, hb, va, vf, vw, vb, div, lat,
                                   input bit hp, vp, input int e);
        exp_t x;
        int ht, vt, n, c, r;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        n  = e / div;
        x = '0;
        x.col  = 10'(n % ht);
        x.row  = 10'((n / ht) % vt);
        x.rv   = (int'(x.row) < va) && (int'(x.col) < ha);
        x.tick = (e > 0) && (e % div == 0);
        x.p    = n - 1 - lat;
        x.hs   = ~hp;
        x.vs   = ~vp;
        if (x.p >= 0) begin
            c = x.p % ht;
            r = (x.p / ht) % vt;
            x.pc = c;
            x.hs = (c >= ha + hf && c < ha + hf + hw) ? hp : ~hp;
            x.vs = (r >= va + vf && r < va + vf + vw) ? vp : ~vp;
            x.de = (r < va) && (c < ha);
            x.fs = (c == 0) && (r == 0) && (e % div == 0);
            x.fc = 16'(x.p / (ht * vt));
        end
        return x;
    endfunction

    // Pixel sources: A returns the requested column 2 requests later, garbage off-tick.
    logic [8:0] hist [3];
    logic [8:0] rtab [256];
    initial begin
        pix_w = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        for (int i = 0; i < 256; i++) rtab[i] = 9'($urandom);
        forever begin
            @(negedge clk);
            if (rst_a) begin
                for (int i = 0; i < 3; i++) hist[i] = '0;
            end else if (a_tick) begin
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = a_col[8:0];
            end
            pix_a = a_tick ? 9'($urandom) : hist[2];
            pix_b = b_col[8:0];
            pix_d = ((e_d + 1) % 3 == 0) ? rtab[(e_d / 3 - 3) & 255] : 9'($urandom);
        end
    end

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_d = 1'b1; rst_w = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({a_hs, a_vs, a_de, a_r, a_g, a_b, a_fc, a_fs, a_tick, a_row, a_col} !==
                {1'b1, 1'b1, 1'b0, 9'd0, 16'd0, 1'b0, 1'b0, 10'd0, 10'd0}) begin
                errors++;
                $display("FAIL reset_a got=%h exp=%h",
                    {a_hs, a_vs, a_de, a_r, a_g, a_b, a_fc, a_fs, a_tick, a_row, a_col},
                    {1'b1, 1'b1, 1'b0, 9'd0, 16'd0, 1'b0, 1'b0, 10'd0, 10'd0});
            end
            checks++;
            if ({b_hs, b_vs, b_de} !== 3'b010) begin
                errors++;
                $display("FAIL reset_b got=%b exp=010", {b_hs, b_vs, b_de});
            end
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0; rst_w = 1'b0;
    endtask

    task automatic test_stream_a();
        exp_t x;
        logic [8:0] ergb;
        logic prev;
        int t = 0, lf = -1, nper = 0;
        prev = a_hs;
        repeat (8000) begin
            @(negedge clk);
            t++;
            x = model(640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0, 1'b0, e_a);
            ergb = x.de ? 9'(x.pc) : 9'd0;
            checks++;
            if ({a_row, a_col, a_valid, a_tick, a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, a_fc} !==
                {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc}) begin
                errors++;
                $display("FAIL stream_a e=%0d got=%h exp=%h", e_a,
                    {a_row, a_col, a_valid, a_tick, a_hs, a_vs, a_de, a_r, a_g, a_b, a_fs, a_fc},
                    {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc});
            end
            if (prev && !a_hs) begin
                if (lf >= 0) begin
                    checks++;
                    nper++;
                    if (t - lf !== 1600) begin
                        errors++;
                        $display("FAIL h_period_a got=%0d exp=1600", t - lf);
                    end
                end
                lf = t;
            end
            if (!prev && a_hs && lf >= 0) begin
                checks++;
                if (t - lf !== 192) begin
                    errors++;
                    $display("FAIL hsync_width_a got=%0d exp=192", t - lf);
                end
            end
            prev = a_hs;
        end
        checks++;
        if (nper < 3) begin
            errors++;
            $display("FAIL h_periods_seen_a got=%0d exp>=3", nper);
        end
    endtask

    task automatic test_polarity_b();
        exp_t x;
        logic [8:0] ergb;
        logic prev;
        int t = 0, lr = -1, nper = 0;
        prev = b_hs;
        repeat (2600) begin
            @(negedge clk);
            t++;
            x = model(640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 1'b1, 1'b0, e_b);
            ergb = x.de ? 9'(x.pc) : 9'd0;
            checks++;
            if ({b_row, b_col, b_valid, b_tick, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs, b_fc} !==
                {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc}) begin
                errors++;
                $display("FAIL stream_b e=%0d got=%h exp=%h", e_b,
                    {b_row, b_col, b_valid, b_tick, b_hs, b_vs, b_de, b_r, b_g, b_b, b_fs, b_fc},
                    {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc});
            end
            if (!prev && b_hs) begin
                if (lr >= 0) begin
                    checks++;
                    nper++;
                    if (t - lr !== 800) begin
                        errors++;
                        $display("FAIL h_period_b got=%0d exp=800", t - lr);
                    end
                end
                lr = t;
            end
            if (prev && !b_hs && lr >= 0) begin
                checks++;
                if (t - lr !== 96) begin
                    errors++;
                    $display("FAIL hsync_high_b got=%0d exp=96", t - lr);
                end
            end
            prev = b_hs;
        end
        checks++;
        if (nper < 2) begin
            errors++;
            $display("FAIL h_periods_seen_b got=%0d exp>=2", nper);
        end
    endtask

    task automatic run_d(input int cycles, input bit measure);
        exp_t x;
        logic [8:0] ergb;
        logic prev;
        int t = 0, lf = -1, nper = 0;
        prev = d_vs;
        repeat (cycles) begin
            @(negedge clk);
            t++;
            x = model(8, 2, 3, 3, 4, 1, 2, 1, 3, 3, 1'b0, 1'b0, e_d);
            ergb = x.de ? rtab[x.p & 255] : 9'd0;
            checks++;
            if ({d_row, d_col, d_valid, d_tick, d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_fc} !==
                {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc}) begin
                errors++;
                $display("FAIL stream_d e=%0d got=%h exp=%h", e_d,
                    {d_row, d_col, d_valid, d_tick, d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_fc},
                    {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, ergb, x.fs, x.fc});
            end
            if (measure && prev && !d_vs) begin
                if (lf >= 0) begin
                    checks++;
                    nper++;
                    if (t - lf !== 384) begin
                        errors++;
                        $display("FAIL v_period_d got=%0d exp=384", t - lf);
                    end
                end
                lf = t;
            end
            if (measure && !prev && d_vs && lf >= 0) begin
                checks++;
                if (t - lf !== 96) begin
                    errors++;
                    $display("FAIL vsync_width_d got=%0d exp=96", t - lf);
                end
            end
            prev = d_vs;
        end
        if (measure) begin
            checks++;
            if (nper < 2) begin
                errors++;
                $display("FAIL v_periods_seen_d got=%0d exp>=2", nper);
            end
        end
    endtask

    task automatic test_vertical_d();
        run_d(3 * 384 + 50, 1'b1);
    endtask

    task automatic test_midframe_reset_d();
        int k = 0;
        while (!(d_row == 10'd2 && d_col == 10'd5 && d_tick) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL midreset_wait got=timeout exp=row2_col5");
        end
        rst_d = 1'b1;
        @(negedge clk);
        checks++;
        if ({d_row, d_col, d_fc, d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_tick} !==
            {10'd0, 10'd0, 16'd0, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_d got=%h exp=%h",
                {d_row, d_col, d_fc, d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_tick},
                {10'd0, 10'd0, 16'd0, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0});
        end
        rst_d = 1'b0;
        run_d(800, 1'b0);
    endtask

    task automatic test_frame_wrap();
        exp_t x;
        int pulses = 0, exp_pulses = 0;
        bit saw_wrap = 1'b0, saw_one = 1'b0;
        repeat (65545) begin
            @(negedge clk);
            x = model(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1'b0, 1'b0, e_w);
            checks++;
            if ({w_row, w_col, w_valid, w_tick, w_hs, w_vs, w_de, w_r, w_g, w_b, w_fs, w_fc} !==
                {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, 3'b000, x.fs, x.fc}) begin
                errors++;
                $display("FAIL wrap_w e=%0d got=%h exp=%h", e_w,
                    {w_row, w_col, w_valid, w_tick, w_hs, w_vs, w_de, w_r, w_g, w_b, w_fs, w_fc},
                    {x.row, x.col, x.rv, x.tick, x.hs, x.vs, x.de, 3'b000, x.fs, x.fc});
            end
            exp_pulses += int'(x.fs);
            if (w_fs) pulses++;
            if (w_fs && w_fc == 16'd0 && pulses > 1) saw_wrap = 1'b1;
            if (saw_wrap && w_fc == 16'd1) saw_one = 1'b1;
        end
        checks++;
        if (pulses !== exp_pulses || exp_pulses < 65537) begin
            errors++;
            $display("FAIL frame_pulses_w got=%0d exp=%0d", pulses, exp_pulses);
        end
        checks++;
        if (!saw_one) begin
            errors++;
            $display("FAIL count_wrap_w got=wrap%0d_one%0d exp=wrap1_one1", saw_wrap, saw_one);
        end
    endtask

    initial begin
        test_reset();
        fork
            test_frame_wrap();
            begin
                test_stream_a();
                test_polarity_b();
                test_vertical_d();
                test_midframe_reset_d();
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
